phase_load_ctrl: RTL and testbench
==================================

PHASE_LOAD_CTRL -- requirements
Module: phase_load_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: number of phase_parser channels, and therefore words per frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum stall between accepted words inside a frame.
REQ-003 SHALL have port clk  input  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_data  input  16  phase word.
REQ-008 SHALL have port in_last  input  1  final word of frame, qualified by in_valid.
REQ-009 SHALL have port sync_tick  input  1  one-cycle pulse marking the drive-period boundary.
REQ-010 SHALL have port out_en  output  1  parser enable; one pulse per forwarded word.
REQ-011 SHALL have port out_data  output  16  phase_data to parsers.
REQ-012 SHALL have port out_start  output  1  high with the out_en of word index 0.
REQ-013 SHALL have port commit  output  1  one-cycle pulse that applies the loaded phases.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have port err  output  3  one-cycle flags {timeout, long, short}.
REQ-016 SHALL have port frame_count  output  16  number of commits issued; wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE, LOAD, FLUSH and WAIT_SYNC.
REQ-018 SHALL treat a word as accepted only on a cycle where in_valid and in_ready are both high.
REQ-019 SHALL drive in_ready high in IDLE, LOAD and FLUSH, and low in WAIT_SYNC.
REQ-020 SHALL register each accepted word in IDLE/LOAD to out_data, with out_en high exactly one cycle later (latency 1).
REQ-021 SHALL hold out_data when out_en is low.
REQ-022 SHALL keep word index idx, 0..NUM_CHANNELS-1; acceptance in IDLE sets idx=0 and the next state is LOAD.
REQ-023 SHALL increment idx by one on each subsequent acceptance in LOAD.
REQ-024 SHALL, on acceptance with in_last and idx==NUM_CHANNELS-1, move to WAIT_SYNC; with NUM_CHANNELS==1 this transition is direct from IDLE.
REQ-025 SHALL, on acceptance with in_last and idx<NUM_CHANNELS-1, pulse err[0] (short) and return to IDLE with no commit.
REQ-026 SHALL, on acceptance at idx==NUM_CHANNELS-1 without in_last, pulse err[1] (long) and enter FLUSH.
REQ-027 SHALL, in FLUSH, discard words without forwarding until an accepted in_last word, then return to IDLE with no commit.
REQ-028 SHALL count consecutive LOAD cycles with no acceptance, clearing the count on each acceptance.
REQ-029 SHALL, when that count reaches TIMEOUT_CYCLES, pulse err[2] and return to IDLE.
REQ-030 SHALL, in WAIT_SYNC, ignore sync_tick on the entry cycle.
REQ-031 SHALL, on a later WAIT_SYNC cycle with sync_tick high, pulse commit on the next cycle, increment frame_count, and return to IDLE.
REQ-032 SHALL register all err bits and commit; each pulse lasts exactly one cycle.
REQ-033 SHALL ignore sync_tick outside WAIT_SYNC.

Reset
REQ-034 SHALL, on rst, asynchronously reset to IDLE, with idx=0 and the stall counter at 0.
REQ-035 SHALL, on rst, force in_ready=0, out_en=0, out_start=0, out_data=0, commit=0, err=0, busy=0 and frame_count=0.
REQ-036 SHALL drive in_ready=1 on the first clock edge after reset is released.
REQ-037 SHALL, on reset mid-frame or in WAIT_SYNC, drop the partial frame and produce no commit.

Structure
REQ-038 SHALL place the state enum, PHASE_W=8, DATA_W=16 and err bit indices in shared package phase_pkg.
REQ-039 SHALL isolate the stall counter as sub-module frame_timer (clear, tick, expired).
REQ-040 SHALL size the idx width as $clog2(NUM_CHANNELS), with a minimum of 1.

Verification (NUM_CHANNELS=4, TIMEOUT_CYCLES=8)
REQ-041 SHALL cover a normal frame: words 0x0101, 0x0202, 0x0303, 0x0404 with last on the 4th, then sync_tick 3 cycles later -> 4 out_en pulses with out_start on the first; commit exactly one cycle after sync_tick; frame_count=1.
REQ-042 SHALL cover a short frame: in_last on the 2nd word -> err=3'b001, state IDLE, no commit even after sync_tick.
REQ-043 SHALL cover a long frame of 6 words with last on the 6th -> err=3'b010 after the 4th word; words 5-6 not forwarded; no commit.
REQ-044 SHALL cover a stall: 2 words, then in_valid low for 8 cycles -> err=3'b100, back to IDLE; a following good frame commits.
REQ-045 SHALL cover backpressure: in WAIT_SYNC with in_valid held high -> in_ready=0, no out_en until after commit.
REQ-046 SHALL cover reset in the middle of word 3 -> all outputs 0 immediately; frame_count unchanged at 0; no commit.

Source files
------------

// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - shared types and constants for the phase load controller
package phase_pkg;

   localparam int PHASE_W = 8;
   localparam int DATA_W  = 16;

   // Bit positions inside the err flag vector
   localparam int ERR_SHORT   = 0;
   localparam int ERR_LONG    = 1;
   localparam int ERR_TIMEOUT = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FLUSH,
      ST_WAIT_SYNC
   } state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - stall counter; expired fires on the tick that reaches TIMEOUT_CYCLES
module frame_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (tick) begin
         count <= count + CW'(1);
      end
   end

   assign expired = tick && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/phase_load_ctrl.sv
// rtl/phase_load_ctrl.sv - frames phase words to the parsers and commits them on sync_tick
module phase_load_ctrl
   import phase_pkg::*;
#(
   parameter int NUM_CHANNELS   = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              sync_tick,
   output logic              out_en,
   output logic [DATA_W-1:0] out_data,
   output logic              out_start,
   output logic              commit,
   output logic              busy,
   output logic [2:0]        err,
   output logic [15:0]       frame_count
);

   localparam int IDX_W = idx_width(NUM_CHANNELS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

   state_t           state, state_next;
   logic [IDX_W-1:0] idx, idx_next, word_idx;
   logic             wait_first, wait_first_next;
   logic             rdy_q;
   logic             accept, fwd, commit_next;
   logic             timer_tick, timer_clear, expired;
   logic [2:0]       err_next;

   // rdy_q holds in_ready low until the first edge after reset
   assign in_ready    = rdy_q && (state != ST_WAIT_SYNC);
   assign accept      = in_valid && in_ready;
   assign busy        = (state != ST_IDLE);
   assign word_idx    = (state == ST_IDLE) ? '0 : idx + IDX_W'(1);
   assign timer_tick  = (state == ST_LOAD) && !accept;
   assign timer_clear = !timer_tick;

   frame_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear),
      .tick    (timer_tick),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         wait_first <= 1'b0;
      end else begin
         state      <= state_next;
         idx        <= idx_next;
         wait_first <= wait_first_next;
      end
   end

   always_comb begin
      state_next      = state;
      idx_next        = idx;
      wait_first_next = 1'b0;
      fwd             = 1'b0;
      commit_next     = 1'b0;
      err_next        = '0;
      case (state)
         ST_IDLE, ST_LOAD: begin
            if (expired) begin
               err_next[ERR_TIMEOUT] = 1'b1;
               state_next            = ST_IDLE;
            end else if (accept) begin
               fwd      = 1'b1;
               idx_next = word_idx;
               if (in_last) begin
                  if (word_idx == LAST_IDX) begin
                     state_next      = ST_WAIT_SYNC;
                     wait_first_next = 1'b1;
                  end else begin
                     err_next[ERR_SHORT] = 1'b1;
                     state_next          = ST_IDLE;
                  end
               end else if (word_idx == LAST_IDX) begin
                  err_next[ERR_LONG] = 1'b1;
                  state_next         = ST_FLUSH;
               end else begin
                  state_next = ST_LOAD;
               end
            end
         end
         ST_FLUSH: begin
            if (accept && in_last) begin
               state_next = ST_IDLE;
            end
         end
         ST_WAIT_SYNC: begin
            // a tick coinciding with the last word belongs to the previous period
            if (sync_tick && !wait_first) begin
               commit_next = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_q       <= 1'b0;
         out_en      <= 1'b0;
         out_start   <= 1'b0;
         out_data    <= '0;
         err         <= '0;
         commit      <= 1'b0;
         frame_count <= '0;
      end else begin
         rdy_q     <= 1'b1;
         out_en    <= fwd;
         out_start <= fwd && (state == ST_IDLE);
         if (fwd) begin
            out_data <= in_data;
         end
         err    <= err_next;
         commit <= commit_next;
         if (commit_next) begin
            frame_count <= frame_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_phase_load_ctrl.sv
// tb/tb_phase_load_ctrl.sv - directed self-checking bench for phase_load_ctrl
module tb_phase_load_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        sync_tick = 1'b0;
   logic        out_en;
   logic [15:0] out_data;
   logic        out_start;
   logic        commit;
   logic        busy;
   logic [2:0]  err;
   logic [15:0] frame_count;

   int tests = 0;
   int fails = 0;

   phase_load_ctrl #(
      .NUM_CHANNELS   (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .sync_tick   (sync_tick),
      .out_en      (out_en),
      .out_data    (out_data),
      .out_start   (out_start),
      .commit      (commit),
      .busy        (busy),
      .err         (err),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a word for one cycle; returns at the following negedge
   task automatic put(input logic [15:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_en", out_en, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_commit", commit, 0);
      chk("rst_err", err, 0);
      chk("rst_frame_count", frame_count, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1);

      // normal frame
      put(16'h0101, 1'b0);
      chk("n_w0_en", out_en, 1);
      chk("n_w0_start", out_start, 1);
      chk("n_w0_data", out_data, 16'h0101);
      chk("n_w0_busy", busy, 1);
      put(16'h0202, 1'b0);
      chk("n_w1_start", out_start, 0);
      chk("n_w1_data", out_data, 16'h0202);
      put(16'h0303, 1'b0);
      chk("n_w2_data", out_data, 16'h0303);
      put(16'h0404, 1'b1);
      chk("n_w3_en", out_en, 1);
      chk("n_w3_data", out_data, 16'h0404);
      chk("n_wait_in_ready", in_ready, 0);
      idle_cycle();
      chk("n_hold_en", out_en, 0);
      chk("n_hold_data", out_data, 16'h0404);
      idle_cycle();
      chk("n_no_early_commit", commit, 0);
      sync_tick = 1'b1;
      idle_cycle();
      sync_tick = 1'b0;
      chk("n_commit", commit, 1);
      chk("n_frame_count", frame_count, 1);
      chk("n_idle_busy", busy, 0);
      idle_cycle();
      chk("n_commit_pulse", commit, 0);

      // short frame
      put(16'h1111, 1'b0);
      put(16'h2222, 1'b1);
      chk("s_err", err, 3'b001);
      chk("s_fwd", out_data, 16'h2222);
      chk("s_busy", busy, 0);
      sync_tick = 1'b1;
      idle_cycle();
      sync_tick = 1'b0;
      chk("s_err_pulse", err, 3'b000);
      idle_cycle();
      chk("s_no_commit", commit, 0);
      chk("s_frame_count", frame_count, 1);

      // long frame
      put(16'h3001, 1'b0);
      put(16'h3002, 1'b0);
      put(16'h3003, 1'b0);
      put(16'h3004, 1'b0);
      chk("l_err", err, 3'b010);
      chk("l_w3_data", out_data, 16'h3004);
      chk("l_flush_ready", in_ready, 1);
      put(16'h3005, 1'b0);
      chk("l_w4_en", out_en, 0);
      chk("l_w4_data", out_data, 16'h3004);
      chk("l_err_pulse", err, 3'b000);
      put(16'h3006, 1'b1);
      chk("l_w5_en", out_en, 0);
      chk("l_busy", busy, 0);
      idle_cycle();
      chk("l_no_commit", commit, 0);
      chk("l_frame_count", frame_count, 1);

      // stall timeout, then a good frame
      put(16'h4001, 1'b0);
      put(16'h4002, 1'b0);
      in_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 7) chk("t_no_err_early", err, 3'b000);
      end
      chk("t_err", err, 3'b100);
      chk("t_busy", busy, 0);
      put(16'h5001, 1'b0);
      chk("t_err_pulse", err, 3'b000);
      chk("t_restart", out_start, 1);
      put(16'h5002, 1'b0);
      put(16'h5003, 1'b0);
      put(16'h5004, 1'b1);
      idle_cycle();
      sync_tick = 1'b1;
      idle_cycle();
      sync_tick = 1'b0;
      chk("t_commit", commit, 1);
      chk("t_frame_count", frame_count, 2);

      // backpressure in WAIT_SYNC; sync_tick on entry cycle is ignored
      put(16'h6001, 1'b0);
      put(16'h6002, 1'b0);
      put(16'h6003, 1'b0);
      put(16'h6004, 1'b1);
      chk("b_in_ready", in_ready, 0);
      in_valid  = 1'b1;
      in_data   = 16'h7777;
      in_last   = 1'b0;
      sync_tick = 1'b1;
      @(negedge clk);
      sync_tick = 1'b0;
      chk("b_entry_tick_ignored", commit, 0);
      chk("b_still_busy", busy, 1);
      chk("b_no_en", out_en, 0);
      chk("b_ready_low", in_ready, 0);
      @(negedge clk);
      chk("b_no_en2", out_en, 0);
      sync_tick = 1'b1;
      @(negedge clk);
      sync_tick = 1'b0;
      chk("b_commit", commit, 1);
      chk("b_frame_count", frame_count, 3);
      chk("b_no_en3", out_en, 0);
      chk("b_ready_back", in_ready, 1);
      @(negedge clk);
      chk("b_after_en", out_en, 1);
      chk("b_after_start", out_start, 1);
      chk("b_after_data", out_data, 16'h7777);

      // reset during word 3
      put(16'h8001, 1'b0);
      chk("r_w1_data", out_data, 16'h8001);
      in_data = 16'h8002;
      #2;
      rst = 1'b1;
      #1;
      chk("r_in_ready", in_ready, 0);
      chk("r_out_en", out_en, 0);
      chk("r_out_start", out_start, 0);
      chk("r_out_data", out_data, 0);
      chk("r_busy", busy, 0);
      chk("r_err", err, 0);
      chk("r_commit", commit, 0);
      chk("r_frame_count", frame_count, 0);
      @(negedge clk);
      rst = 1'b0;
      idle_cycle();
      chk("r_ready_again", in_ready, 1);
      sync_tick = 1'b1;
      idle_cycle();
      sync_tick = 1'b0;
      idle_cycle();
      chk("r_no_commit", commit, 0);
      chk("r_frame_count_after", frame_count, 0);
      chk("r_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
